mem_controller: RTL

// - Shares one external data-memory channel (read + write ports) among NUM_CONSUMERS LSUs.
// - Per-LSU valid/ready request ports face the LSUs; one valid/ready port pair faces memory.
// - Serves one transaction at a time; round-robin arbitration; relays read data back to the requester.

---
 rtl/mem_controller.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mem_controller.sv
// Purpose: shares one external memory read/write channel among NUM_CONSUMERS LSUs, round-robin.
// Latency: request -> mem valid next cycle; mem ready -> consumer ready next cycle; one IDLE cycle between grants.
// Backpressure: one transaction in flight; losers keep valid high until granted, ready held until valid drops.
module mem_controller #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_write_ready
);

  localparam int ID_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam logic [ID_BITS-1:0] LAST_ID = ID_BITS'(NUM_CONSUMERS - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    READ_RELAY,
    WRITE_RELAY
  } state_t;

  state_t             state;
  logic [ID_BITS-1:0] rr_ptr;
  logic [ID_BITS-1:0] grant;

  logic               arb_found;
  logic               arb_read;
  logic [ID_BITS-1:0] arb_id;
  logic [ID_BITS-1:0] cand;

  // Round-robin scan starting at rr_ptr; a consumer asserting both read and write gets its read first.
  always_comb begin
    arb_found = 1'b0;
    arb_read  = 1'b0;
    arb_id    = '0;
    cand      = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      cand = ID_BITS'((int'(rr_ptr) + i) % NUM_CONSUMERS);
      if (!arb_found && (consumer_read_valid[cand] || consumer_write_valid[cand])) begin
        arb_found = 1'b1;
        arb_read  = consumer_read_valid[cand];
        arb_id    = cand;
      end
    end
  end

  // Transaction FSM; all outputs are registered here and address/data are captured at grant time.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      rr_ptr               <= '0;
      grant                <= '0;
      consumer_read_ready  <= '0;
      consumer_read_data   <= '0;
      consumer_write_ready <= '0;
      mem_read_valid       <= 1'b0;
      mem_read_address     <= '0;
      mem_write_valid      <= 1'b0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_found) begin
            grant <= arb_id;
            if (arb_read) begin
              mem_read_valid   <= 1'b1;
              mem_read_address <= consumer_read_address[arb_id*ADDR_BITS +: ADDR_BITS];
              state            <= READ_WAIT;
            end else begin
              mem_write_valid   <= 1'b1;
              mem_write_address <= consumer_write_address[arb_id*ADDR_BITS +: ADDR_BITS];
              mem_write_data    <= consumer_write_data[arb_id*DATA_BITS +: DATA_BITS];
              state             <= WRITE_WAIT;
            end
          end
        end
        READ_WAIT: begin
          if (mem_read_ready) begin
            mem_read_valid                                   <= 1'b0;
            consumer_read_data[grant*DATA_BITS +: DATA_BITS] <= mem_read_data;
            consumer_read_ready[grant]                       <= 1'b1;
            state                                            <= READ_RELAY;
          end
        end
        WRITE_WAIT: begin
          if (mem_write_ready) begin
            mem_write_valid             <= 1'b0;
            consumer_write_ready[grant] <= 1'b1;
            state                       <= WRITE_RELAY;
          end
        end
        READ_RELAY: begin
          // Ready stays up until the requester lets go of valid.
          if (!consumer_read_valid[grant]) begin
            consumer_read_ready[grant] <= 1'b0;
            rr_ptr                     <= (grant == LAST_ID) ? '0 : grant + 1'b1;
            state                      <= IDLE;
          end
        end
        WRITE_RELAY: begin
          if (!consumer_write_valid[grant]) begin
            consumer_write_ready[grant] <= 1'b0;
            rr_ptr                      <= (grant == LAST_ID) ? '0 : grant + 1'b1;
            state                       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
